// File: rtl/puf_challenge_sequencer.sv
// Arbiter-PUF challenge sequencer: steps an LFSR challenge through a mux chain,
// pulses Launch for a settle window and collects one arbiter bit per challenge.
module puf_challenge_sequencer #(
   parameter int unsigned RESP_BITS     = 16,
   parameter int unsigned SETTLE_CYCLES = 8
) (
   input  logic                 Clock,
   input  logic                 Reset,
   input  logic                 Start,
   input  logic [31:0]          Seed,
   output logic [31:0]          Challenge,
   output logic                 Launch,
   input  logic                 ArbiterOut,
   output logic [RESP_BITS-1:0] Response,
   output logic                 ResponseValid,
   input  logic                 ResponseReady,
   output logic                 Busy
);

   typedef enum logic [2:0] {IDLE, APPLY, RACE, SAMPLE, DONE} state_t;

   localparam logic [7:0] SETTLE_LAST = 8'(SETTLE_CYCLES - 1);
   localparam logic [5:0] BIT_LAST    = 6'(RESP_BITS - 1);

   state_t     state;
   logic [7:0] settle_cnt;
   logic [5:0] bit_cnt;
   logic       fb;

   always_comb begin
      fb = Challenge[31] ^ Challenge[21] ^ Challenge[1] ^ Challenge[0];
   end

   always_ff @(posedge Clock) begin
      if (Reset) begin
         state         <= IDLE;
         Challenge     <= '0;
         Launch        <= 1'b0;
         Response      <= '0;
         ResponseValid <= 1'b0;
         Busy          <= 1'b0;
         settle_cnt    <= '0;
         bit_cnt       <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (Start) begin
                  // an all-zero seed would lock the LFSR
                  Challenge <= (Seed == '0) ? 32'h0000_0001 : Seed;
                  Response  <= '0;
                  bit_cnt   <= '0;
                  Busy      <= 1'b1;
                  state     <= APPLY;
               end
            end
            APPLY: begin
               settle_cnt <= SETTLE_LAST;
               Launch     <= 1'b1;
               state      <= RACE;
            end
            RACE: begin
               if (settle_cnt == '0) begin
                  Launch <= 1'b0;
                  state  <= SAMPLE;
               end else begin
                  settle_cnt <= settle_cnt - 8'd1;
               end
            end
            SAMPLE: begin
               for (int unsigned i = 0; i < RESP_BITS; i++) begin
                  if (bit_cnt == 6'(i)) Response[i] <= ArbiterOut;
               end
               bit_cnt   <= bit_cnt + 6'd1;
               Challenge <= {Challenge[30:0], fb};
               if (bit_cnt == BIT_LAST) begin
                  ResponseValid <= 1'b1;
                  state         <= DONE;
               end else begin
                  state <= APPLY;
               end
            end
            DONE: begin
               if (ResponseReady) begin
                  ResponseValid <= 1'b0;
                  Busy          <= 1'b0;
                  state         <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: doc/puf_challenge_sequencer.md
PUF_CHALLENGE_SEQUENCER -- requirements
Module: puf_challenge_sequencer

Interface
REQ-001 SHALL have parameter RESP_BITS, default 16: number of response bits collected per run (range 1..32).
REQ-002 SHALL have parameter SETTLE_CYCLES, default 8: cycles Launch is held high before sampling (range 1..255).
REQ-003 SHALL have port Clock, input, 1: the single clock; all logic on its rising edge.
REQ-004 SHALL have port Reset, input, 1: synchronous, active-high reset.
REQ-005 SHALL have port Start, input, 1: run request, sampled only in IDLE.
REQ-006 SHALL have port Seed, input, 32: initial challenge, latched when Start is accepted.
REQ-007 SHALL have port Challenge, output, 32: drives the Selection inputs of the 32-stage mux chain.
REQ-008 SHALL have port Launch, output, 1: drives both Input0/Input1 at the head of the chain.
REQ-009 SHALL have port ArbiterOut, input, 1: arbiter decision at the tail of the chain.
REQ-010 SHALL have port Response, output, RESP_BITS: collected response word.
REQ-011 SHALL have port ResponseValid, output, 1: Response is complete and stable.
REQ-012 SHALL have port ResponseReady, input, 1: consumer accepts Response.
REQ-013 SHALL have port Busy, output, 1: high in every state except IDLE.

Function
REQ-014 SHALL implement FSM states IDLE, APPLY, RACE, SAMPLE, DONE.
REQ-015 SHALL, in IDLE with Start=1, load Challenge from Seed (Seed=0 substituted by 0x00000001), clear Response and bit counter, and enter APPLY next cycle.
REQ-016 SHALL hold Launch=0 in IDLE, APPLY, SAMPLE, DONE; APPLY lasts exactly 1 cycle, then RACE.
REQ-017 SHALL drive Launch=1 for exactly SETTLE_CYCLES consecutive cycles in RACE, then enter SAMPLE.
REQ-018 SHALL, at the clock edge ending the single SAMPLE cycle, write ArbiterOut into Response[bitcount], increment bitcount, and advance the challenge LFSR.
REQ-019 SHALL step the LFSR as: fb = C[31]^C[21]^C[1]^C[0]; C <= {C[30:0], fb}.
REQ-020 SHALL hold Challenge constant throughout APPLY, RACE and SAMPLE of each bit.
REQ-021 SHALL go SAMPLE -> APPLY while bitcount < RESP_BITS after increment, else SAMPLE -> DONE.
REQ-022 SHALL take exactly SETTLE_CYCLES+2 cycles per bit; ResponseValid rises RESP_BITS*(SETTLE_CYCLES+2) cycles after the Start-accept edge.
REQ-023 SHALL assert ResponseValid only in DONE, holding Response stable until a cycle with ResponseReady=1, then enter IDLE.
REQ-024 SHALL ignore Start in every state except IDLE, including the DONE-handshake cycle (Start must be re-sampled in IDLE).
REQ-025 SHALL bit-order Response so the first challenge's result is bit 0.
REQ-026 SHALL keep Challenge at its final advanced value in DONE and IDLE until the next accepted Start.

Reset
REQ-027 SHALL, when Reset=1 at a clock edge, force state IDLE, Challenge=0, Launch=0, Response=0, ResponseValid=0, Busy=0, counters=0.
REQ-028 SHALL let Reset override any state, including mid-RACE (Launch drops the next cycle) and DONE (pending Response discarded).
REQ-029 SHALL give Reset priority over Start in the same cycle.

Verification
REQ-030 SHALL test defaults, Seed=0x12345678, ArbiterOut held 1, ResponseReady=1 -> ResponseValid at cycle 160 after Start accept, Response=0xFFFF, then IDLE, Busy=0.
REQ-031 SHALL test Seed=0 -> first Challenge=0x00000001, second=0x00000003; Seed=0x80000000 -> second Challenge=0x00000001.
REQ-032 SHALL test ArbiterOut = Challenge[0] per bit, Seed=0x00000001 -> Response bits match the expected LFSR bit-0 sequence; Launch high exactly 8 cycles per bit, low 2.
REQ-033 SHALL test ResponseReady=0 for 20 cycles in DONE -> ResponseValid and Response held; Start pulses ignored; handshake then returns IDLE.
REQ-034 SHALL test Reset asserted during bit 5 RACE -> next cycle Launch=0, Challenge=0, Busy=0, Response=0; subsequent Start runs a clean full sequence.
REQ-035 SHALL test RESP_BITS=1, SETTLE_CYCLES=1 -> ResponseValid 3 cycles after Start accept.
